// File: rtl/md_sequencer_pkg.sv
// Shared constants for the multiply/divide sequencer: command encodings,
// default latencies and a small arithmetic helper.
package md_sequencer_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned OP_W         = 4;
    localparam int unsigned BUSY_W       = 8;
    localparam int unsigned DEF_MULT_LAT = 5;
    localparam int unsigned DEF_DIV_LAT  = 10;

    typedef enum logic [OP_W-1:0] {
        mdNONE  = 4'd0,
        mdMULT  = 4'd1,
        mdMULTU = 4'd2,
        mdDIV   = 4'd3,
        mdDIVU  = 4'd4,
        mdMTHI  = 4'd5,
        mdMTLO  = 4'd6,
        mdMFHI  = 4'd7,
        mdMFLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] abs32(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? DATA_W'(-v) : v;
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: produces the 64-bit {hi, lo} value
// that the sequencer commits once the operation latency has expired.
module md_arith
    import md_sequencer_pkg::*;
(
    input  logic [OP_W-1:0]     md_op,
    input  logic [DATA_W-1:0]   rs_val,
    input  logic [DATA_W-1:0]   rt_val,
    input  logic [DATA_W-1:0]   hi,
    input  logic [DATA_W-1:0]   lo,
    output logic [2*DATA_W-1:0] pending
);

    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;
    logic [DATA_W-1:0]   mag_n;
    logic [DATA_W-1:0]   mag_d;
    logic [DATA_W-1:0]   mag_q;
    logic [DATA_W-1:0]   mag_r;
    logic [DATA_W-1:0]   quo_s;
    logic [DATA_W-1:0]   rem_s;
    logic [DATA_W-1:0]   quo_u;
    logic [DATA_W-1:0]   rem_u;
    logic                div_zero;

    assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};
    assign prod_s = 64'($signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val}));

    // Signed divide on magnitudes: quotient truncates toward zero, remainder
    // follows the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign div_zero = (rt_val == 32'd0);
    assign mag_n    = abs32(rs_val);
    assign mag_d    = abs32(rt_val);
    assign mag_q    = div_zero ? 32'd0 : mag_n / mag_d;
    assign mag_r    = div_zero ? 32'd0 : mag_n % mag_d;
    assign quo_s    = (rs_val[31] ^ rt_val[31]) ? 32'(-mag_q) : mag_q;
    assign rem_s    = rs_val[31] ? 32'(-mag_r) : mag_r;
    assign quo_u    = div_zero ? 32'd0 : rs_val / rt_val;
    assign rem_u    = div_zero ? 32'd0 : rs_val % rt_val;

    always_comb begin
        pending = 64'd0;
        case (md_op_e'(md_op))
            mdMULT:  pending = prod_s;
            mdMULTU: pending = prod_u;
            mdDIV:   pending = div_zero ? {hi, lo} : {rem_s, quo_s};
            mdDIVU:  pending = div_zero ? {hi, lo} : {rem_u, quo_u};
            default: pending = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide resource owner: HI/LO, fixed-latency busy counter and the
// pending result that is committed when the counter expires.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int unsigned MULT_LAT = DEF_MULT_LAT,
    parameter int unsigned DIV_LAT  = DEF_DIV_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   md_op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              req,
    output logic [BUSY_W-1:0] busy,
    output logic [DATA_W-1:0] md_out,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    md_state_e           state;
    logic [2*DATA_W-1:0] pending;
    logic [2*DATA_W-1:0] arith_res;

    md_arith u_arith (
        .md_op   (md_op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .hi      (hi),
        .lo      (lo),
        .pending (arith_res)
    );

    // Issue only from IDLE with no flush; an in-flight operation always runs to commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= '0;
            hi      <= '0;
            lo      <= '0;
            pending <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !req) begin
                        case (md_op_e'(md_op))
                            mdMULT, mdMULTU: begin
                                pending <= arith_res;
                                busy    <= BUSY_W'(MULT_LAT);
                                state   <= RUN;
                            end
                            mdDIV, mdDIVU: begin
                                pending <= arith_res;
                                busy    <= BUSY_W'(DIV_LAT);
                                state   <= RUN;
                            end
                            mdMTHI:  hi <= rs_val;
                            mdMTLO:  lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    busy <= busy - BUSY_W'(1);
                    if (busy == BUSY_W'(1)) begin
                        hi    <= pending[2*DATA_W-1:DATA_W];
                        lo    <= pending[DATA_W-1:0];
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        md_out = '0;
        case (md_op_e'(md_op))
            mdMFHI:  md_out = hi;
            mdMFLO:  md_out = lo;
            default: md_out = '0;
        endcase
    end

endmodule
